// File: rtl/mdclcg_mux_sched.sv
// mdclcg_mux_sched
//   Scheduler for the 64-bit 2:1 lane mux. It shares one output stream
//   between two generator lanes, sequences the generator warm-up and
//   buffers one output word.
//
// Handshake rules (all interfaces):
//   A word moves across an interface on a rising edge where its valid and
//   ready are both 1. A lane's ready is a same-cycle grant. It is never high
//   unless that lane's valid is high. At most one lane is granted per cycle.
//   out_valid stays high and out_data stays stable until out_ready is
//   sampled high.
//
// Parameters
//   WARMUP : warm-up cycles (warm_en high) before the first word is accepted
//   CNT_W  : width of word_cnt
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   start, stop               : run control levels (stop wins over start)
//   lane0_data / lane1_data   : lane words (mux in0 / in1)
//   lane0_valid / lane1_valid : lane word available
//   lane0_ready / lane1_ready : lane word consumed this cycle
//   sel                       : mux select, 1 = lane1
//   out_data, out_valid       : registered output word and its valid
//   out_ready                 : downstream accepts out_data
//   warm_en                   : steps the generator lanes during warm-up
//   busy                      : FSM is not in IDLE
//   word_cnt                  : output transfers since the last start
//   dbg_state                 : current FSM state (0 IDLE, 1 WARM, 2 RUN, 3 DRAIN)
module mdclcg_mux_sched #(
  parameter int WARMUP = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [63:0]      lane0_data,
  input  logic [63:0]      lane1_data,
  input  logic             lane0_valid,
  input  logic             lane1_valid,
  output logic             lane0_ready,
  output logic             lane1_ready,
  output logic             sel,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             warm_en,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic [1:0]       dbg_state
);

  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARM  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    warm_cnt_q, warm_cnt_d;
  logic             ptr_q, ptr_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic xfer;
  logic slot_open;
  logic any_valid;
  logic grant_idx;
  logic grant_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      warm_cnt_q  <= '0;
      ptr_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    warm_en     = 1'b0;
    grant_en    = 1'b0;

    xfer      = out_valid_q && out_ready;
    slot_open = !out_valid_q || out_ready;
    any_valid = lane0_valid || lane1_valid;
    // Pointer lane wins when valid; otherwise fall to the other lane.
    grant_idx = ptr_q ? lane1_valid : !lane0_valid;

    // The buffered word leaves on a transfer; a grant below refills it.
    out_valid_d = out_valid_q && !out_ready;
    if (xfer) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          word_cnt_d = '0;
          if (WARMUP == 0) begin
            state_d    = S_RUN;
            warm_cnt_d = '0;
          end else begin
            state_d    = S_WARM;
            warm_cnt_d = WW'(WARMUP - 1);
          end
        end
      end
      S_WARM: begin
        if (stop) begin
          state_d    = S_IDLE;
          warm_cnt_d = '0;
        end else begin
          warm_en = 1'b1;
          if (warm_cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            warm_cnt_d = warm_cnt_q - WW'(1);
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (slot_open && any_valid) begin
          grant_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (slot_open) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_en) begin
      out_data_d  = grant_idx ? lane1_data : lane0_data;
      out_valid_d = 1'b1;
      ptr_d       = !grant_idx;
    end
  end

  assign sel         = grant_en ? grant_idx : ptr_q;
  assign lane0_ready = grant_en && !grant_idx;
  assign lane1_ready = grant_en && grant_idx;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign word_cnt    = word_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mdclcg_mux_sched.sv
module tb_mdclcg_mux_sched;

  localparam int WARMUP = 4;
  localparam int CNT_W  = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam logic [63:0] WORD_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WORD_5 = 64'h5555_5555_5555_5555;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop;
  logic [63:0]      lane0_data, lane1_data;
  logic             lane0_valid, lane1_valid;
  logic             lane0_ready, lane1_ready;
  logic             sel;
  logic [63:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             warm_en;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mdclcg_mux_sched #(.WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .lane0_data(lane0_data), .lane1_data(lane1_data),
    .lane0_valid(lane0_valid), .lane1_valid(lane1_valid),
    .lane0_ready(lane0_ready), .lane1_ready(lane1_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .warm_en(warm_en), .busy(busy),
    .word_cnt(word_cnt), .dbg_state(dbg_state)
  );

  // driver tasks: inputs change 1 ns after a rising edge, outputs are
  // sampled 2 ns after it, far from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; out_ready = 0;
    lane0_valid = 0; lane1_valid = 0; lane0_data = '0; lane1_data = '0;
    repeat (3) step();
    settle();
    tests_run++;
    if ({busy, out_valid, warm_en, sel, lane0_ready, lane1_ready} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, out_valid, warm_en, sel, lane0_ready, lane1_ready});
    end
    tests_run++;
    if (word_cnt !== 4'd0 || out_data !== 64'd0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_regs: cnt %0d data %h state %0d expected 0 0 0",
               word_cnt, out_data, dbg_state);
    end
    rst_n = 1'b1;
    step();
  endtask

  // Leaves the bench in the first RUN cycle with both lanes valid.
  task automatic test_warmup();
    int warm_cycles = 0;
    int budget = 20;
    lane0_data = WORD_A; lane1_data = WORD_5;
    lane0_valid = 1; lane1_valid = 1; out_ready = 1;
    start = 1;
    step();
    start = 0;
    settle();
    while (warm_en === 1'b1 && budget > 0) begin
      warm_cycles++;
      tests_run++;
      if ({lane0_ready, lane1_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL warm_ready: got %b expected 00", {lane0_ready, lane1_ready});
      end
      budget--;
      step();
      settle();
    end
    tests_run++;
    if (warm_cycles !== WARMUP) begin
      tests_failed++;
      $display("FAIL warm_len: got %0d cycles expected %0d", warm_cycles, WARMUP);
    end
    tests_run++;
    if (dbg_state !== ST_RUN || word_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL warm_to_run: state %0d cnt %0d expected 2 0", dbg_state, word_cnt);
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if ({sel, lane0_ready, lane1_ready} !== ((k % 2 == 0) ? 3'b010 : 3'b101)) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", k,
                 {sel, lane0_ready, lane1_ready}, (k % 2 == 0) ? 3'b010 : 3'b101);
      end
      step();
      settle();
      tests_run++;
      if (out_data !== ((k % 2 == 0) ? WORD_A : WORD_5) || out_valid !== 1'b1 ||
          word_cnt !== CNT_W'(k)) begin
        tests_failed++;
        $display("FAIL rr_word[%0d]: data %h valid %b cnt %0d expected %h 1 %0d", k,
                 out_data, out_valid, word_cnt, (k % 2 == 0) ? WORD_A : WORD_5, k);
      end
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 0;
    settle();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({lane0_ready, lane1_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL bp_ready[%0d]: got %b expected 00", k, {lane0_ready, lane1_ready});
      end
      step();
      settle();
      tests_run++;
      if (out_data !== WORD_5 || out_valid !== 1'b1 || word_cnt !== 4'd5) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: data %h valid %b cnt %0d expected %h 1 5", k,
                 out_data, out_valid, word_cnt, WORD_5);
      end
    end
    out_ready = 1;
    settle();
    tests_run++;
    if ({sel, lane0_ready, lane1_ready} !== 3'b010) begin
      tests_failed++;
      $display("FAIL bp_release: got %b expected 010", {sel, lane0_ready, lane1_ready});
    end
    step();
    settle();
    tests_run++;
    if (out_data !== WORD_A || word_cnt !== 4'd6) begin
      tests_failed++;
      $display("FAIL bp_next: data %h cnt %0d expected %h 6", out_data, word_cnt, WORD_A);
    end
  endtask

  // Only lane1 valid; ten transfers also carry word_cnt through its wrap.
  task automatic test_single_lane();
    lane0_valid = 0;
    for (int i = 0; i < 10; i++) begin
      lane1_data = 64'h1000 + 64'(i);
      settle();
      tests_run++;
      if ({sel, lane0_ready, lane1_ready} !== 3'b101) begin
        tests_failed++;
        $display("FAIL single_grant[%0d]: got %b expected 101", i,
                 {sel, lane0_ready, lane1_ready});
      end
      step();
      settle();
      tests_run++;
      if (out_data !== 64'h1000 + 64'(i) || word_cnt !== CNT_W'(7 + i)) begin
        tests_failed++;
        $display("FAIL single_word[%0d]: data %h cnt %0d expected %h %0d", i,
                 out_data, word_cnt, 64'h1000 + 64'(i), (7 + i) % 16);
      end
    end
  endtask

  task automatic test_stop_drain();
    lane0_valid = 1; lane1_valid = 1; out_ready = 0; stop = 1;
    settle();
    tests_run++;
    if ({lane0_ready, lane1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stop_nogrant: got %b expected 00", {lane0_ready, lane1_ready});
    end
    step();
    stop = 0;
    settle();
    tests_run++;
    if (dbg_state !== ST_DRAIN || out_valid !== 1'b1 || out_data !== 64'h1009 ||
        {lane0_ready, lane1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL drain_hold: state %0d valid %b data %h rdy %b expected 3 1 1009 00",
               dbg_state, out_valid, out_data, {lane0_ready, lane1_ready});
    end
    out_ready = 1;
    settle();
    tests_run++;
    if ({lane0_ready, lane1_ready, busy} !== 3'b001) begin
      tests_failed++;
      $display("FAIL drain_xfer_ready: got %b expected 001", {lane0_ready, lane1_ready, busy});
    end
    step();
    settle();
    tests_run++;
    if (dbg_state !== ST_IDLE || out_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL drain_done: state %0d valid %b busy %b cnt %0d expected 0 0 0 1",
               dbg_state, out_valid, busy, word_cnt);
    end
    start = 1; stop = 1;
    step();
    settle();
    tests_run++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || word_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL start_stop_idle: state %0d busy %b cnt %0d expected 0 0 1",
               dbg_state, busy, word_cnt);
    end
  endtask

  task automatic test_warm_stop();
    start = 1; stop = 0;
    step();
    start = 0;
    settle();
    tests_run++;
    if (dbg_state !== ST_WARM || warm_en !== 1'b1 || word_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL warm_enter: state %0d warm_en %b cnt %0d expected 1 1 0",
               dbg_state, warm_en, word_cnt);
    end
    stop = 1;
    settle();
    tests_run++;
    if (warm_en !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL warm_stop_comb: warm_en %b busy %b expected 0 1", warm_en, busy);
    end
    step();
    stop = 0;
    settle();
    tests_run++;
    if (dbg_state !== ST_IDLE || warm_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL warm_stop_idle: state %0d warm_en %b expected 0 0", dbg_state, warm_en);
    end
  endtask

  task automatic test_async_reset();
    int budget = 20;
    lane0_data = WORD_A; lane1_data = WORD_5;
    lane0_valid = 1; lane1_valid = 1; out_ready = 1;
    start = 1;
    step();
    start = 0;
    settle();
    while (dbg_state !== ST_RUN && budget > 0) begin
      budget--;
      step();
      settle();
    end
    tests_run++;
    if (dbg_state !== ST_RUN) begin
      tests_failed++;
      $display("FAIL ar_reach_run: state %0d expected 2", dbg_state);
    end
    repeat (3) step();
    out_ready = 0;
    step();
    settle();
    tests_run++;
    if (out_valid !== 1'b1 || word_cnt !== 4'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ar_pre: valid %b cnt %0d busy %b expected 1 2 1", out_valid, word_cnt, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, busy, warm_en, sel, lane0_ready, lane1_ready} !== 6'b0 ||
        word_cnt !== 4'd0 || out_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL ar_async: ctrl %b cnt %0d data %h expected 000000 0 0",
               {out_valid, busy, warm_en, sel, lane0_ready, lane1_ready}, word_cnt, out_data);
    end
    out_ready = 1;
    step();
    rst_n = 1'b1;
    step();
    settle();
    tests_run++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_release: state %0d busy %b valid %b expected 0 0 0",
               dbg_state, busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_round_robin();
    test_back_pressure();
    test_single_lane();
    test_stop_drain();
    test_warm_stop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mdclcg_mux_sched.md
MDCLCG_MUX_SCHED -- requirements
Module: mdclcg_mux_sched

Purpose: scheduler for the 64-bit 2:1 lane mux; shares one output stream between two generator lanes, sequences warm-up, and buffers one output word.

Interface
REQ-001 SHALL have parameter WARMUP, default 16: number of warm-up cycles before the first word is accepted.
REQ-002 SHALL have parameter CNT_W, default 32: width of word_cnt.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: level sampled each cycle; begins a run from IDLE.
REQ-006 SHALL have port stop, input, 1: level sampled each cycle; ends warm-up or run.
REQ-007 SHALL have ports lane0_data and lane1_data, input, 64: lane words, fed to mux in0 and in1 respectively.
REQ-008 SHALL have ports lane0_valid and lane1_valid, input, 1: each lane's word is available.
REQ-009 SHALL have ports lane0_ready and lane1_ready, output, 1: lane word consumed this cycle.
REQ-010 SHALL have port sel, output, 1: mux select; 1 selects lane1, 0 selects lane0.
REQ-011 SHALL have port out_data, output, 64: registered output word.
REQ-012 SHALL have port out_valid, output, 1: out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-014 SHALL have port warm_en, output, 1: steps the generator lanes during warm-up.
REQ-015 SHALL have port busy, output, 1: FSM is not in IDLE.
REQ-016 SHALL have port word_cnt, output, CNT_W: count of output transfers since the last start.

Function
REQ-017 SHALL implement four FSM states: IDLE, WARM, RUN and DRAIN.
REQ-018 IDLE: start=1 and stop=0 SHALL clear word_cnt and go to WARM, loading the warm-up counter with WARMUP-1. If WARMUP=0 it SHALL go directly to RUN.
REQ-019 IDLE: start=1 together with stop=1 SHALL be ignored; stop wins.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 WARM: warm_en=1 each cycle and the counter decrements. At count 0 the FSM SHALL go to RUN, so warm_en is high for exactly WARMUP cycles.
REQ-022 WARM: stop=1 SHALL go to IDLE on the next edge; warm_en SHALL drop in that same cycle.
REQ-023 warm_en SHALL be 0 in every state except WARM, and lane ready signals SHALL be 0 in IDLE, WARM and DRAIN.
REQ-024 RUN: a slot SHALL be open when out_valid=0 or out_ready=1.
REQ-025 RUN: in an open slot, the block SHALL grant one valid lane using round-robin. The lane named by the priority pointer wins a tie; if only one lane is valid, that lane is granted.
REQ-026 Grant SHALL be combinational within the cycle: the granted lane's ready=1, sel=granted index, out_data<=selected word, out_valid<=1, and the pointer<=the non-granted lane.
REQ-027 At most one laneN_ready SHALL be high per cycle; a lane with valid=0 SHALL never see ready=1.
REQ-028 With no grant, sel SHALL equal the pointer, and out_valid SHALL clear when out_valid&&out_ready.
REQ-029 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 RUN: stop=1 SHALL go to DRAIN with no grant in that cycle.
REQ-031 DRAIN: no grants. The FSM SHALL go to IDLE on the edge where out_valid=0, or where out_valid&&out_ready.
REQ-032 word_cnt SHALL increment on each out_valid&&out_ready and wrap from 2^CNT_W-1 to 0.
REQ-033 busy SHALL be 1 in WARM, RUN and DRAIN.

Reset
REQ-034 While rst_n=0, regardless of clk, the block SHALL force: state=IDLE; pointer=0; out_data=0; out_valid=0; word_cnt=0; warm-up counter=0.
REQ-035 Consequently, during reset sel=0, warm_en=0, busy=0 and both lane ready signals=0.
REQ-036 Reset asserted mid-run SHALL discard any buffered word with no lane ready pulse. The first edge after rst_n rises SHALL leave the block in IDLE.

Verification
REQ-037 Warm-up: WARMUP=4, start pulse -> warm_en high exactly 4 cycles, then RUN; no lane ready during warm-up.
REQ-038 Round-robin: both lanes valid with 0xA..A / 0x5..5, out_ready=1 -> out_data alternates lane0, lane1, lane0 …; sel toggles every cycle; word_cnt +1 per cycle.
REQ-039 Back-pressure: out_ready=0 for 3 cycles with a buffered word -> out_data unchanged and both readies 0; on out_ready=1, the next lane is granted the same cycle.
REQ-040 Single lane: only lane1_valid=1 -> every grant goes to lane1 and lane0_ready stays 0.
REQ-041 Stop/drain: stop in RUN with out_valid=1 -> DRAIN, no new grant; IDLE after the word transfers. start and stop together in IDLE -> stays IDLE.
REQ-042 Async reset: rst_n low mid-cycle in RUN -> out_valid=0, busy=0 and word_cnt=0 immediately, without waiting for a clock edge.
